memc_deskew: RTL and testbench
==============================

Name: memc_deskew

Overview:
- Output-side counterpart to the B/A skew buffers. Receives the result matrix C from the bottom edge of the DIM x DIM systolic array.
- Columns arrive staggered: lane i is one cycle later than lane i-1. The block delays each lane so that every row of C comes out aligned in a single cycle.
- Tags each aligned row with an index and signals completion once all DIM rows have been produced.

Parameters:
- BITS_C, 24, signed width of each C element.
- DIM, 8, array dimension; this is both the number of lanes and the number of rows per matrix.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that arms a new collection; honoured only in IDLE.
- en  input  1  asserted on each cycle in which lane 0 holds a valid C element (row r of column 0).
- Cin  input  [BITS_C-1:0] x DIM (signed, unpacked)  skewed array outputs; lane i carries row r at the en cycle + i.
- Cout  output  [BITS_C-1:0] x DIM (signed, unpacked)  deskewed row.
- out_valid  output  1  Cout holds a complete aligned row.
- row_idx  output  $clog2(DIM)  index of the row currently on Cout.
- busy  output  1  high in COLLECT and DRAIN.
- done  output  1  one-cycle pulse after the last row is output.

Behaviour:
- Reset (asynchronous, rst_n low):
  - All delay registers, Cout, out_valid, row_idx, busy and done clear to 0.
  - FSM returns to IDLE.
  - Reset mid-operation discards all in-flight data; no done pulse is produced.
- Deskew pipeline:
  - Lane i passes through exactly DIM-i registers. Lane 0 has DIM stages; lane DIM-1 has 1 stage.
  - Registers shift every cycle, regardless of state.
  - An element entering lane i at cycle t0+r+i reaches Cout at cycle t0+r+DIM for every lane, so latency is DIM cycles measured from the lane-0 en cycle.
  - No arithmetic is performed; values pass bit-exact and keep their sign.
- Valid pipeline:
  - An internal capture bit equals (en AND state==COLLECT). It shifts through a DIM-stage register chain.
  - out_valid is the output of that chain, aligned with Cout.
  - en outside COLLECT is ignored: it never raises out_valid and never advances any counter.
- Counters:
  - in_cnt counts accepted en cycles.
  - row_idx counts out_valid cycles. It presents 0 on the first valid row, increments after each valid row, and wraps to 0 after DIM-1.
  - Both counters clear when the FSM enters COLLECT.
- FSM states and transitions:
  - IDLE: start moves to COLLECT. start in any other state is ignored.
  - COLLECT: accepts en. After the DIM-th accepted en, next state is DRAIN.
  - DRAIN: stays until the out_valid cycle carrying row_idx==DIM-1, then goes to DONE.
  - DONE: done=1 for exactly one cycle, then returns to IDLE.
  - busy = (state==COLLECT or state==DRAIN).
- Gaps and ordering:
  - en may be non-contiguous (bubbles allowed). out_valid reproduces the identical gap pattern DIM cycles later.
  - start and en in the same cycle while in IDLE: that en is not accepted, because capture starts the following cycle.
  - Rows are output in arrival order.
- Cout when out_valid is low holds pipeline contents, which are don't-care. The bench must check Cout only when out_valid=1.

Test Plan:
- Basic deskew, DIM=8:
  - Stimulus: start, then en for 8 contiguous cycles; lane i of row r driven with value 100*r+i at cycle r+i after the first en.
  - Response: out_valid high for cycles 8..15 after the first en; Cout[i]=100*r+i on row r; row_idx 0..7; done pulses 1 cycle after row 7; busy then low.
- Signed pass-through:
  - Stimulus: lane 3 carries -5 (0xFFFFFB) and lane 7 carries 0x7FFFFF.
  - Response: both values appear unchanged in the aligned row.
- Bubbles:
  - Stimulus: en pattern 1,1,0,0,1,1,1,1,1,1.
  - Response: out_valid shows the identical pattern 8 cycles later; row_idx advances only on valid cycles; done after the 8th row.
- Ignored controls:
  - Stimulus: en asserted in IDLE; start asserted during COLLECT.
  - Response: no out_valid from the IDLE en; counters unaffected; exactly 8 rows and one done.
- Reset mid-operation:
  - Stimulus: assert rst_n low after 4 rows have been output.
  - Response: immediately out_valid=0, busy=0, state IDLE, no done. A fresh start then yields a clean 8-row collection with row_idx starting at 0.
- Back-to-back matrices:
  - Stimulus: start again in the cycle after done.
  - Response: the second matrix is collected correctly, row_idx restarts at 0, and a second done pulse follows.

Source files
------------

// File: rtl/memc_deskew.sv
// memc_deskew
// ---------------------------------------------------------------------------
// Output-side deskew for the DIM x DIM systolic array. The array delivers
// row r of C staggered across lanes: lane i carries it one cycle later than
// lane i-1. Each lane is delayed by DIM-i registers so that the whole row
// appears aligned on Cout, DIM cycles after the lane-0 'en' cycle. Aligned
// rows are tagged with row_idx, and 'done' pulses once all DIM rows of a
// matrix have been produced.
//
// Ports
//   clk        clock
//   rst_n      asynchronous active-low reset (clears all state and data)
//   start      arms a new collection; honoured only while idle
//   en         lane 0 holds a valid element this cycle
//   Cin        skewed array outputs, one signed element per lane
//   Cout       deskewed row (don't-care while out_valid is low)
//   out_valid  Cout holds a complete aligned row
//   row_idx    index of the row currently on Cout
//   busy       collecting or draining
//   done       one-cycle pulse after the last row of a matrix
//
// DIM must be at least 2.
// ---------------------------------------------------------------------------
module memc_deskew #(
  parameter int BITS_C = 24,
  parameter int DIM    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     en,
  input  logic signed [BITS_C-1:0] Cin [DIM],
  output logic signed [BITS_C-1:0] Cout [DIM],
  output logic                     out_valid,
  output logic [$clog2(DIM)-1:0]   row_idx,
  output logic                     busy,
  output logic                     done
);

  localparam int CNT_W = $clog2(DIM);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(DIM - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    FINISH  = 2'd3
  } state_t;

  state_t             state_r;
  logic               cap_s;
  logic [DIM-1:0]     vld_r;
  logic [CNT_W-1:0]   in_cnt_r;
  logic [CNT_W-1:0]   row_idx_r;
  logic               busy_r;
  logic               done_r;

  // Capture qualifier: en only counts while a collection is open.
  always_comb begin
    cap_s = en && (state_r == COLLECT);
  end

  // Valid chain: DIM stages so out_valid lines up with the lane-0 data path,
  // reproducing any bubble pattern in en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r <= '0;
    end else begin
      vld_r <= {vld_r[DIM-2:0], cap_s};
    end
  end

  assign out_valid = vld_r[DIM-1];

  // Per-lane delay lines. Lane i is already i cycles late on arrival, so it
  // gets DIM-i stages; the last stage of every lane drives Cout directly.
  for (genvar i = 0; i < DIM; i++) begin : g_lane
    localparam int DEPTH = DIM - i;
    logic signed [BITS_C-1:0] stg_r [DEPTH];

    // Shift every cycle regardless of FSM state; data is passed bit-exact.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < DEPTH; k++) begin
          stg_r[k] <= '0;
        end
      end else begin
        stg_r[0] <= Cin[i];
        for (int k = 1; k < DEPTH; k++) begin
          stg_r[k] <= stg_r[k-1];
        end
      end
    end

    assign Cout[i] = stg_r[DEPTH-1];
  end

  // Control FSM with counters and registered busy/done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      in_cnt_r  <= '0;
      row_idx_r <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      // row_idx advances after every presented row and wraps after DIM-1.
      if (out_valid) begin
        if (row_idx_r == LAST_ROW) begin
          row_idx_r <= '0;
        end else begin
          row_idx_r <= row_idx_r + CNT_W'(1);
        end
      end else begin
        row_idx_r <= row_idx_r;
      end

      case (state_r)
        IDLE: begin
          if (start) begin
            state_r   <= COLLECT;
            in_cnt_r  <= '0;
            row_idx_r <= '0;
            busy_r    <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        COLLECT: begin
          if (en) begin
            in_cnt_r <= in_cnt_r + CNT_W'(1);
            if (in_cnt_r == LAST_ROW) begin
              state_r <= DRAIN;
            end else begin
              state_r <= COLLECT;
            end
          end else begin
            state_r <= COLLECT;
          end
        end
        DRAIN: begin
          // Leave once the final row is on the output this cycle.
          if (out_valid && (row_idx_r == LAST_ROW)) begin
            state_r <= FINISH;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= DRAIN;
          end
        end
        FINISH: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign row_idx = row_idx_r;
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: tb/tb_memc_deskew.sv
// Testbench for memc_deskew: directed matrices, transaction-level model that
// predicts per-cycle outputs, and a single compare process on the falling edge.
module tb_memc_deskew;

  localparam int BITS_C = 24;
  localparam int DIM    = 8;
  localparam int NCYC   = 1024;

  typedef logic [BITS_C-1:0] row_t [DIM];

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     start = 1'b0;
  logic                     en = 1'b0;
  logic signed [BITS_C-1:0] Cin [DIM];
  logic signed [BITS_C-1:0] Cout [DIM];
  logic                     out_valid;
  logic [2:0]               row_idx;
  logic                     busy;
  logic                     done;

  memc_deskew #(.BITS_C(BITS_C), .DIM(DIM)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .en        (en),
    .Cin       (Cin),
    .Cout      (Cout),
    .out_valid (out_valid),
    .row_idx   (row_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Stimulus data per cycle/lane and expected outputs per cycle.
  logic [BITS_C-1:0] in_val    [NCYC][DIM];
  bit                exp_valid [NCYC];
  bit                exp_busy  [NCYC];
  bit                exp_done  [NCYC];
  int                exp_idx   [NCYC];
  logic [BITS_C-1:0] exp_row   [NCYC][DIM];

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  // Transaction-level model state.
  bit m_act     = 1'b0;
  int m_st      = 0;
  int m_acc     = 0;
  int m_last    = -1;
  int m_done_at = -1;
  int m_free    = 0;

  int t1_en = -100;
  int t_sg  = -100;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, want);
    end
  endtask

  function automatic row_t mkrow(input int tag, input int r);
    row_t v;
    for (int i = 0; i < DIM; i++) begin
      v[i] = BITS_C'(tag * 1000 + 100 * r + i);
    end
    return v;
  endfunction

  // One clock cycle of stimulus plus the model's view of it.
  task automatic do_cycle(input bit rst, input bit st, input bit e, input row_t v);
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      rst_n = 1'b0;
      start = 1'b0;
      en    = 1'b0;
      m_act     = 1'b0;
      m_done_at = -1;
      m_free    = cyc + 1;
      for (int c = cyc; c < cyc + 3 * DIM && c < NCYC; c++) begin
        exp_valid[c] = 1'b0;
        exp_busy[c]  = 1'b0;
        exp_done[c]  = 1'b0;
      end
    end else begin
      rst_n = 1'b1;
      start = st;
      en    = e;
      exp_busy[cyc] = m_act && (cyc > m_st) && ((m_last < 0) || (cyc <= m_last));
      exp_done[cyc] = (cyc == m_done_at);
      if (m_act && (m_last >= 0) && (cyc > m_last)) m_act = 1'b0;
      if (st && !m_act && (cyc >= m_free)) begin
        m_act  = 1'b1;
        m_st   = cyc;
        m_acc  = 0;
        m_last = -1;
      end
      if (e && m_act && (cyc > m_st) && (m_acc < DIM)) begin
        exp_valid[cyc + DIM] = 1'b1;
        exp_idx[cyc + DIM]   = m_acc;
        exp_row[cyc + DIM]   = v;
        m_acc++;
        if (m_acc == DIM) begin
          m_last    = cyc + DIM;
          m_done_at = m_last + 1;
          m_free    = m_last + 2;
        end
      end
      if (e) begin
        for (int i = 0; i < DIM; i++) in_val[cyc + i][i] = v[i];
      end
    end
    for (int i = 0; i < DIM; i++) Cin[i] = in_val[cyc][i];
  endtask

  task automatic idle(input int n);
    row_t z;
    for (int i = 0; i < DIM; i++) z[i] = '0;
    for (int k = 0; k < n; k++) do_cycle(1'b0, 1'b0, 1'b0, z);
  endtask

  task automatic matrix(input int tag);
    for (int r = 0; r < DIM; r++) do_cycle(1'b0, 1'b0, 1'b1, mkrow(tag, r));
  endtask

  // Compare process: every cycle on the falling edge.
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid[cyc]});
      chk("busy", {31'd0, busy}, {31'd0, exp_busy[cyc]});
      chk("done", {31'd0, done}, {31'd0, exp_done[cyc]});
      if (!rst_n) begin
        chk("rst_row_idx", {29'd0, row_idx}, 32'd0);
        chk("rst_cout0", {8'd0, Cout[0]}, 32'd0);
      end
      if (exp_valid[cyc] && out_valid) begin
        chk("row_idx", {29'd0, row_idx}, exp_idx[cyc]);
        for (int i = 0; i < DIM; i++) begin
          chk($sformatf("cout%0d", i), {8'd0, Cout[i]}, {8'd0, exp_row[cyc][i]});
        end
      end
      // Hand-computed pins for the basic and signed matrices.
      if (cyc == t1_en + 8) begin
        chk("pin_r0_l3", {8'd0, Cout[3]}, 32'd3);
        chk("pin_r0_idx", {29'd0, row_idx}, 32'd0);
      end
      if (cyc == t1_en + 10) chk("pin_r2_l5", {8'd0, Cout[5]}, 32'd205);
      if (cyc == t1_en + 15) begin
        chk("pin_r7_l7", {8'd0, Cout[7]}, 32'd707);
        chk("pin_r7_idx", {29'd0, row_idx}, 32'd7);
      end
      if (cyc == t1_en + 16) begin
        chk("pin_done", {31'd0, done}, 32'd1);
        chk("pin_busy", {31'd0, busy}, 32'd0);
      end
      if (cyc == t_sg + 8) begin
        chk("pin_neg5", {8'd0, Cout[3]}, 32'h00FF_FFFB);
        chk("pin_max", {8'd0, Cout[7]}, 32'h007F_FFFF);
      end
    end
  end

  initial begin
    row_t z;
    row_t v;
    int   pat [10];
    int   guard;
    pat = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
    for (int i = 0; i < DIM; i++) z[i] = '0;
    for (int c = 0; c < NCYC; c++) begin
      exp_valid[c] = 1'b0;
      exp_busy[c]  = 1'b0;
      exp_done[c]  = 1'b0;
      exp_idx[c]   = 0;
      for (int i = 0; i < DIM; i++) begin
        in_val[c][i]  = BITS_C'($urandom);
        exp_row[c][i] = '0;
      end
    end
    for (int i = 0; i < DIM; i++) Cin[i] = in_val[0][i];

    // Reset, then a basic contiguous matrix.
    repeat (3) do_cycle(1'b1, 1'b0, 1'b0, z);
    idle(2);
    do_cycle(1'b0, 1'b1, 1'b0, z);
    t1_en = cyc + 1;
    matrix(0);
    idle(12);

    // Signed pass-through on row 0.
    do_cycle(1'b0, 1'b1, 1'b0, z);
    t_sg = cyc + 1;
    for (int r = 0; r < DIM; r++) begin
      v = mkrow(2, r);
      if (r == 0) begin
        v[3] = 24'hFF_FFFB;
        v[7] = 24'h7F_FFFF;
      end
      do_cycle(1'b0, 1'b0, 1'b1, v);
    end
    idle(12);

    // Bubbles in en.
    do_cycle(1'b0, 1'b1, 1'b0, z);
    for (int k = 0; k < 10; k++) do_cycle(1'b0, 1'b0, pat[k] != 0, mkrow(3, k));
    idle(12);

    // Ignored controls: en in idle, start+en together, start mid-collection,
    // start and en while draining.
    for (int k = 0; k < 3; k++) do_cycle(1'b0, 1'b0, 1'b1, mkrow(9, k));
    do_cycle(1'b0, 1'b1, 1'b1, mkrow(9, 5));
    for (int r = 0; r < DIM; r++) do_cycle(1'b0, r == 4, 1'b1, mkrow(4, r));
    do_cycle(1'b0, 1'b1, 1'b1, mkrow(9, 6));
    do_cycle(1'b0, 1'b0, 1'b1, mkrow(9, 7));
    idle(12);

    // Reset after four rows have come out, then a clean matrix.
    do_cycle(1'b0, 1'b1, 1'b0, z);
    matrix(5);
    idle(4);
    repeat (2) do_cycle(1'b1, 1'b0, 1'b0, z);
    idle(1);
    do_cycle(1'b0, 1'b1, 1'b0, z);
    matrix(6);
    idle(12);

    // Back-to-back: start in the cycle right after done.
    do_cycle(1'b0, 1'b1, 1'b0, z);
    matrix(7);
    guard = 0;
    while ((cyc + 1 < m_free) && (guard < 100)) begin
      idle(1);
      guard++;
    end
    do_cycle(1'b0, 1'b1, 1'b0, z);
    matrix(8);
    idle(12);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
